// File: rtl/bkram_sd_ctrl.sv
// bkram_sd_ctrl: streams backup RAM to/from an SD image one 512-byte sector at a time, and formats it.
// Define BKRAM_AUTOSAVE_EN to add an idle-timer automatic save after the core dirties the RAM.
module bkram_sd_ctrl #(
    parameter int          SEC_W           = 4,
    parameter int          SLOT_W          = 2,
    parameter logic [15:0] HDR0            = 16'h5548,
    parameter logic [15:0] HDR1            = 16'h4D42,
    parameter logic [15:0] HDR2            = 16'h8800,
    parameter logic [15:0] HDR3            = 16'h8010,
    parameter logic [31:0] AUTOSAVE_CYCLES = 32'd50_000_000
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                downloading,
    input  logic                img_mounted,
    input  logic                img_readonly,
    input  logic                img_size_nz,
    input  logic                load_req,
    input  logic                save_req,
    input  logic                format_req,
    input  logic [SLOT_W-1:0]   slot,
    input  logic                dirty_set,
    output logic                ena,
    output logic                busy,
    output logic                loading,
    output logic                done,
    output logic [31:0]         sd_lba,
    output logic                sd_rd,
    output logic                sd_wr,
    input  logic                sd_ack,
    input  logic [7:0]          sd_buff_addr,
    input  logic [15:0]         sd_buff_dout,
    input  logic                sd_buff_wr,
    output logic [15:0]         sd_buff_din,
    output logic [SEC_W+7:0]    ram_addr,
    output logic [15:0]         ram_wdata,
    output logic                ram_we,
    input  logic [15:0]         ram_q
);
    localparam int AW = SEC_W + 8;

    typedef enum logic [2:0] {IDLE, FMT_CLR, FMT_HDR, REQ, XFER, FIN} state_t;

    state_t            r_state, w_next;
    logic              r_load_d, r_save_d, r_fmt_d, r_dl_d, r_ack_d;
    logic              r_ena, r_mode_load;
    logic [SEC_W-1:0]  r_sec;
    logic [AW-1:0]     r_cnt;
    logic [31:0]       r_lba;
    logic              w_load_e, w_save_e, w_fmt_e, w_ack_rise, w_ack_fall;
    logic              w_start_fmt, w_start_io, w_start_load, w_auto;
    logic              w_ena_set, w_xfer, w_fmt;
    logic [SLOT_W-1:0] w_slot;
    logic [15:0]       w_hdr;

    assign w_load_e   = load_req & ~r_load_d;
    assign w_save_e   = save_req & ~r_save_d;
    assign w_fmt_e    = format_req & ~r_fmt_d;
    assign w_ack_rise = sd_ack & ~r_ack_d;
    assign w_ack_fall = ~sd_ack & r_ack_d;
    assign w_ena_set  = downloading & img_mounted & img_size_nz & ~img_readonly;

`ifdef BKRAM_AUTOSAVE_EN
    logic              r_dirty;
    logic [31:0]       r_idle;
    logic [SLOT_W-1:0] r_last;

    assign w_auto = r_dirty & r_ena & (r_idle == '0);
    assign w_slot = (w_load_e | w_save_e) ? slot : r_last;

    // Any save (manual or automatic) clears dirty; a core write in the same cycle wins.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dirty <= 1'b0;
            r_idle  <= '0;
            r_last  <= '0;
        end else begin
            if (w_start_io)
                r_last <= w_slot;
            if (dirty_set) begin
                r_dirty <= 1'b1;
                r_idle  <= AUTOSAVE_CYCLES;
            end else begin
                if (w_start_io && !w_start_load)
                    r_dirty <= 1'b0;
                if (r_state == IDLE && r_idle != '0)
                    r_idle <= r_idle - 32'd1;
            end
        end
    end
`else
    logic [32:0] w_unused;

    assign w_unused = {dirty_set, AUTOSAVE_CYCLES};
    assign w_auto   = 1'b0;
    assign w_slot   = slot;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_start_fmt  = 1'b0;
        w_start_io   = 1'b0;
        w_start_load = 1'b0;
        case (r_state)
            IDLE: begin
                w_start_fmt  = w_fmt_e;
                w_start_io   = ~w_fmt_e & ((r_ena & (w_load_e | w_save_e)) | w_auto);
                w_start_load = w_start_io & w_load_e;
                w_next       = w_start_fmt ? FMT_CLR : w_start_io ? REQ : IDLE;
            end
            FMT_CLR: w_next = (&r_cnt) ? FMT_HDR : FMT_CLR;
            FMT_HDR: w_next = (r_cnt[1:0] == 2'd3) ? FIN : FMT_HDR;
            REQ:     w_next = w_ack_rise ? XFER : REQ;
            XFER:    w_next = w_ack_fall ? ((&r_sec) ? FIN : REQ) : XFER;
            default: w_next = IDLE;
        endcase
    end

    // Edge detectors run unconditionally so a level held across an operation never retriggers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_load_d    <= 1'b0;
            r_save_d    <= 1'b0;
            r_fmt_d     <= 1'b0;
            r_dl_d      <= 1'b0;
            r_ack_d     <= 1'b0;
            r_ena       <= 1'b0;
            r_mode_load <= 1'b0;
            r_sec       <= '0;
            r_cnt       <= '0;
            r_lba       <= '0;
        end else begin
            r_load_d <= load_req;
            r_save_d <= save_req;
            r_fmt_d  <= format_req;
            r_dl_d   <= downloading;
            r_ack_d  <= sd_ack;
            r_ena    <= w_ena_set | (r_ena & ~(downloading & ~r_dl_d));
            if (w_start_fmt) begin
                r_cnt       <= '0;
                r_mode_load <= 1'b0;
            end else if (r_state == FMT_CLR || r_state == FMT_HDR) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_start_io) begin
                r_lba       <= 32'({w_slot, {SEC_W{1'b0}}});
                r_sec       <= '0;
                r_mode_load <= w_start_load;
            end else if (r_state == XFER && w_ack_fall && !(&r_sec)) begin
                r_lba <= r_lba + 32'd1;
                r_sec <= r_sec + 1'b1;
            end
        end
    end

    assign w_xfer = (r_state == XFER) & sd_ack;
    assign w_fmt  = (r_state == FMT_CLR) | (r_state == FMT_HDR);
    assign w_hdr  = (r_cnt[1:0] == 2'd0) ? HDR0 :
                    (r_cnt[1:0] == 2'd1) ? HDR1 :
                    (r_cnt[1:0] == 2'd2) ? HDR2 : HDR3;

    assign ena         = r_ena;
    assign busy        = r_state != IDLE;
    assign loading     = r_mode_load & ((r_state == REQ) | (r_state == XFER) | (r_state == FIN));
    assign done        = r_state == FIN;
    assign sd_lba      = r_lba;
    assign sd_rd       = (r_state == REQ) & r_mode_load;
    assign sd_wr       = (r_state == REQ) & ~r_mode_load;
    assign sd_buff_din = ram_q;
    assign ram_addr    = w_xfer ? {r_sec, sd_buff_addr} : w_fmt ? r_cnt : '0;
    assign ram_we      = w_xfer ? (r_mode_load & sd_buff_wr) : w_fmt;
    assign ram_wdata   = (w_xfer & r_mode_load) ? sd_buff_dout :
                         (r_state == FMT_HDR) ? w_hdr : 16'h0000;
endmodule

// File: tb/tb_bkram_sd_ctrl.sv
// tb_bkram_sd_ctrl: directed bench for bkram_sd_ctrl with a small hps_io sector model.
// Covers mount/ena vectors, load, save, format, request collisions, mid-save reset and (macro builds) autosave.
module tb_bkram_sd_ctrl;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        downloading = 1'b0, img_mounted = 1'b0, img_readonly = 1'b0, img_size_nz = 1'b0;
    logic        load_req = 1'b0, save_req = 1'b0, format_req = 1'b0, dirty_set = 1'b0;
    logic [1:0]  slot = 2'd0;
    logic        ena, busy, loading, done, sd_rd, sd_wr, ram_we;
    logic [31:0] sd_lba;
    logic        sd_ack = 1'b0, sd_buff_wr = 1'b0;
    logic [7:0]  sd_buff_addr = 8'h00;
    logic [15:0] sd_buff_dout = 16'h0000, ram_q = 16'h0000;
    logic [15:0] sd_buff_din, ram_wdata;
    logic [11:0] ram_addr;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic dl;
        logic m;
        logic ro;
        logic nz;
        logic e;
    } vec_t;

    bkram_sd_ctrl #(.AUTOSAVE_CYCLES(32'd100)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .downloading(downloading),
        .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size_nz(img_size_nz),
        .load_req(load_req), .save_req(save_req), .format_req(format_req), .slot(slot),
        .dirty_set(dirty_set), .ena(ena), .busy(busy), .loading(loading), .done(done),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
        .sd_buff_din(sd_buff_din), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // One hps_io sector handshake, checking port B addressing word by word.
    task automatic sector(input logic ld, input logic [31:0] exp_lba, input logic [3:0] sec);
        int n = 0;
        while (!(sd_rd | sd_wr) && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", 32'(n < 20), 1);
        chk("no_done", done, 0);
        chk("lba", sd_lba, exp_lba);
        chk("rd", sd_rd, ld);
        chk("wr", sd_wr, !ld);
        chk("loading", loading, ld);
        sd_ack = 1'b1;
        tick();
        chk("req_drop", {sd_rd, sd_wr}, 0);
        for (int a = 0; a < 256; a++) begin
            sd_buff_addr = 8'(a);
            sd_buff_dout = 16'({sec, 8'(a)}) ^ 16'hA55A;
            ram_q        = 16'({sec, 8'(a)}) ^ 16'h3C3C;
            sd_buff_wr   = ld;
            #1;
            chk("xfer_addr", ram_addr, {sec, 8'(a)});
            chk("xfer_we", ram_we, ld);
            if (ld)
                chk("xfer_wdata", ram_wdata, 16'({sec, 8'(a)}) ^ 16'hA55A);
            else
                chk("buff_din", sd_buff_din, 16'({sec, 8'(a)}) ^ 16'h3C3C);
            tick();
        end
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        tick();
    endtask

    task automatic run_xfer(input logic ld, input logic [31:0] base, input int sv_at);
        for (int s = 0; s < 16; s++) begin
            if (s == sv_at)
                save_req = 1'b1;
            sector(ld, base + 32'(s), 4'(s));
        end
        chk("done_pulse", done, 1);
        chk("loading_fin", loading, ld);
        tick();
        chk("done_clear", done, 0);
        chk("idle_after", busy, 0);
        chk("loading_off", loading, 0);
    endtask

    task automatic mount_rw();
        downloading = 1'b0;
        tick();
        downloading = 1'b1; img_mounted = 1'b1; img_size_nz = 1'b1; img_readonly = 1'b0;
        tick();
        downloading = 1'b0; img_mounted = 1'b0;
        tick();
        chk("mount_ena", ena, 1);
    endtask

    initial begin
        vec_t        tv[11];
        logic [15:0] hdr[4];
        int          n, bad, we_n;
        tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tv[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tv[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tv[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        hdr = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_ena", ena, 0);
        chk("rst_sd", {sd_rd, sd_wr, ram_we, done, loading}, 0);
        chk("rst_lba", sd_lba, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        #3 reset_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            downloading = tv[i].dl; img_mounted = tv[i].m;
            img_readonly = tv[i].ro; img_size_nz = tv[i].nz;
            tick();
            chk($sformatf("ena_vec%0d", i), ena, tv[i].e);
        end

        slot = 2'd2;
        load_req = 1'b1;
        tick();
        chk("load_busy", busy, 1);
        chk("load_rd", sd_rd, 1);
        chk("load_loading", loading, 1);
        chk("load_lba", sd_lba, 32);
        load_req = 1'b0;
        run_xfer(1'b1, 32, -1);

        slot = 2'd1;
        load_req = 1'b1;
        save_req = 1'b1;
        tick();
        chk("coll_rd", sd_rd, 1);
        chk("coll_wr", sd_wr, 0);
        load_req = 1'b0;
        save_req = 1'b0;
        run_xfer(1'b1, 16, 3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("coll_no_save", {busy, sd_wr}, 0);
        end
        save_req = 1'b0;

        downloading = 1'b1; img_mounted = 1'b1; img_readonly = 1'b1; img_size_nz = 1'b1;
        tick();
        chk("ro_ena", ena, 0);
        downloading = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0;
        save_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ro_no_save", {busy, sd_wr}, 0);
        end
        save_req = 1'b0;

        format_req = 1'b1;
        tick();
        format_req = 1'b0;
        n = 0; bad = 0; we_n = 0;
        while (busy && n < 6000) begin
            if (ram_we) begin
                we_n++;
                if (n < 4096) begin
                    if (ram_addr !== 12'(n) || ram_wdata !== 16'h0000)
                        bad++;
                end else if (n < 4100) begin
                    chk("hdr_addr", ram_addr, n - 4096);
                    chk("hdr_data", ram_wdata, hdr[n - 4096]);
                end
            end
            if (n == 4100)
                chk("fmt_done", done, 1);
            n++;
            tick();
        end
        chk("fmt_busy_cycles", n, 4101);
        chk("fmt_we_cycles", we_n, 4100);
        chk("fmt_clr_bad", bad, 0);

        mount_rw();
        slot = 2'd3;
        save_req = 1'b1;
        tick();
        chk("save_wr", sd_wr, 1);
        chk("save_loading", loading, 0);
        save_req = 1'b0;
        for (int s = 0; s < 5; s++)
            sector(1'b0, 48 + 32'(s), 4'(s));
        chk("s5_lba", sd_lba, 53);
        sd_ack = 1'b1;
        tick();
        sd_buff_addr = 8'h10;
        #1;
        chk("s5_addr", ram_addr, 12'h510);
        reset_n = 1'b0;
        #1;
        chk("arst_ena", ena, 0);
        chk("arst_busy", busy, 0);
        chk("arst_flags", {loading, done, sd_rd, sd_wr, ram_we}, 0);
        chk("arst_lba", sd_lba, 0);
        chk("arst_addr", ram_addr, 0);
        chk("arst_wdata", ram_wdata, 0);
        sd_ack = 1'b0;
        tick();
        #2 reset_n = 1'b1;
        tick();
        chk("post_rst_ena", ena, 0);
        chk("post_rst_busy", busy, 0);
        tick();
        chk("post_rst_idle", {busy, sd_wr, sd_rd}, 0);

`ifdef BKRAM_AUTOSAVE_EN
        mount_rw();
        slot = 2'd2;
        dirty_set = 1'b1;
        tick();
        dirty_set = 1'b0;
        n = 0;
        while (!sd_wr && n < 300) begin
            tick();
            n++;
        end
        chk("auto_delay", 32'(n >= 99 && n <= 102), 1);
        chk("auto_lba", sd_lba, 0);
        run_xfer(1'b0, 0, -1);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (busy || sd_wr)
                bad++;
        end
        chk("auto_once", bad, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bkram_sd_ctrl.md
# bkram_sd_ctrl

Parametrised backup-RAM ↔ SD-image streaming controller for the emu top level. It replaces the inline save/load/format logic with a reusable block that supports configurable slot count, sector count and format pattern. It moves BRAM contents one 512-byte sector at a time over the hps_io `sd_*` buffer interface. It also holds the core in reset while a load is in progress. The backup RAM itself is an external dual-port RAM; this block drives that RAM's port B.

## Interface
Parameters:
- `SEC_W`, 4: log2 sectors per slot; sectors per slot = 2^SEC_W, each sector 256 × 16-bit words.
- `SLOT_W`, 2: log2 number of save slots.
- `HDR0..HDR3`, 16'h5548, 16'h4D42, 16'h8800, 16'h8010: header words written to addresses 0..3 by format.
- `AUTOSAVE_CYCLES`, 32'd50_000_000: idle cycles after the last dirty write before an automatic save (macro builds only).

Ports:
- `clk_sys` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `downloading` in 1: ROM download in progress.
- `img_mounted` in 1: save-image mount strobe.
- `img_readonly` in 1: mounted image is read-only.
- `img_size_nz` in 1: mounted image size ≠ 0.
- `load_req` in 1: level; rising edge requests a load.
- `save_req` in 1: level; rising edge requests a save.
- `format_req` in 1: level; rising edge requests a format.
- `slot` in SLOT_W: slot index, sampled when a request is accepted.
- `dirty_set` in 1: core wrote BRAM (ignored unless macro defined).
- `ena` out 1: a valid save image is mounted.
- `busy` out 1: an operation is in progress.
- `loading` out 1: load in progress; the core is held in reset.
- `done` out 1: one-cycle pulse at the end of any operation.
- `sd_lba` out 32: sector address.
- `sd_rd` out 1: sector read request.
- `sd_wr` out 1: sector write request.
- `sd_ack` in 1: hps_io sector transfer acknowledge.
- `sd_buff_addr` in 8: word index within the current sector.
- `sd_buff_dout` in 16: data from hps_io.
- `sd_buff_wr` in 1: data-from-hps_io strobe.
- `sd_buff_din` out 16: data to hps_io (= `ram_q`).
- `ram_addr` out SEC_W+8: RAM port B address.
- `ram_wdata` out 16: RAM port B write data.
- `ram_we` out 1: RAM port B write enable.
- `ram_q` in 16: RAM port B read data, 1-cycle latency.

## Operation
- `ena`:
  - Cleared on the rising edge of `downloading`.
  - Set when `downloading & img_mounted & img_size_nz & ~img_readonly`.
- States: `IDLE`, `FMT_CLR`, `FMT_HDR`, `REQ`, `XFER`, `FIN`.
- `IDLE` request handling:
  - Load or save rising edge with `ena`=1 → `REQ`.
  - `sd_lba` ← {slot, SEC_W'0}, zero-extended to 32 bits.
  - Sector counter ← 0.
  - Mode ← load or save.
  - If load and save edges coincide, load wins.
- `IDLE` format handling:
  - Format rising edge → `FMT_CLR`.
  - `ena` is not required.
  - Format has priority over load and save.
- `FMT_CLR`:
  - Writes 0 to every word, address 0 upward, one word per cycle.
  - → `FMT_HDR`.
- `FMT_HDR`:
  - Writes HDR0..HDR3 to addresses 0..3.
  - → `FIN`.
- `REQ`:
  - Asserts `sd_rd` (load) or `sd_wr` (save).
  - On the `sd_ack` rising edge: drop `sd_rd`/`sd_wr` → `XFER`.
- `XFER`, while `sd_ack`=1:
  - `ram_addr` = {sector, `sd_buff_addr`}.
  - Load: `ram_we` = `sd_buff_wr`, `ram_wdata` = `sd_buff_dout`.
- `XFER`, on the `sd_ack` falling edge:
  - Last sector (counter all ones) → `FIN`.
  - Otherwise: `sd_lba`+1, sector+1 → `REQ`.
- `FIN`: pulse `done` → `IDLE`.
- `loading` = 1 from load acceptance through `FIN`.
- Requests arriving while `busy` are dropped, not queued. Edge detectors keep running so a held level does not retrigger.
- `ena` falling mid-transfer does not abort the operation.

## Timing
- Reset values:
  - `ena`, `busy`, `loading`, `done`, `sd_rd`, `sd_wr`, `ram_we`: 0.
  - `sd_lba`, `ram_addr`, `ram_wdata`: 0.
  - State = `IDLE`.
- Reset mid-operation aborts immediately; no partial recovery.
- Request edge at cycle N → `busy`=1 and `sd_rd`/`sd_wr`=1 at N+1.
- `sd_ack` rising edge sampled at cycle M → `sd_rd`/`sd_wr`=0 at M+1.
- `ram_addr`/`ram_we` are combinational from the `sd_*` inputs during `XFER`. hps_io sees read data (`sd_buff_din`) one cycle after an address change.
- Format duration: 2^(SEC_W+8) + 4 write cycles, plus 1 cycle in `FIN`. `busy` is high throughout.
- Sector counter wraps only via `FIN`. `sd_lba` never crosses into the next slot.

## Configuration
- `BKRAM_AUTOSAVE_EN` defined:
  - `dirty_set` sets a dirty flag and reloads an idle counter to `AUTOSAVE_CYCLES`.
  - The counter decrements in `IDLE`.
  - At 0 with dirty=1 and `ena`=1: start a save to the last-used slot (0 after reset) and clear dirty.
  - `dirty_set` during an operation re-sets dirty.
  - A manual save clears dirty.
- Not defined: `dirty_set` is ignored, no counter is built, and saves occur only on `save_req`.

## Test plan
- Mount writable image (`img_size_nz`=1) during download, slot=2, `load_req` edge → 16 sectors with `sd_lba` 32..47. `loading`=1 throughout. Word written to `ram_addr` 0x1A5 equals `sd_buff_dout` at sector 1, `sd_buff_addr` 0xA5. One `done` pulse.
- `img_readonly`=1 at mount, then `save_req` edge → `ena`=0, no `sd_wr`, `busy` stays 0.
- `format_req` edge → 4096 zero writes followed by 0x5548, 0x4D42, 0x8800, 0x8010 at addresses 0..3. `busy` high for 4101 cycles.
- `load_req` and `save_req` rising in the same cycle → load performed. A second `save_req` edge during the load is ignored (no `sd_wr` afterwards).
- `reset_n` low during sector 5 of a save → all outputs at reset values the same cycle. After release, `ena`=0 and the state is `IDLE`.
- With `BKRAM_AUTOSAVE_EN`, AUTOSAVE_CYCLES=100, one `dirty_set` pulse → save to last slot starts 100 cycles later. No second save without a new `dirty_set`.
